w_stage_grf: RTL and testbench
==============================

Name: w_stage_grf

Overview:
- Write-back end of the M/W pipeline register. Consumes the W-stage bundle the M/W register emits: instr, PC8, ALU result, memory read data, write number and write enable.
- Selects the write-back source and sign/zero-extends sub-word loads. Writes the 32x32 general register file (GRF).
- Serves two combinational D-stage read ports with internal write-through bypass.
- Keeps a retired-instruction counter and a registered write-trace port for the testbench and grader.

Parameters:
- RESET_PC, 32'h0000_3000, base PC; trace_pc reports PC8-8 and is compared against this base in the bench.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- W_instr  input  32  W-stage instruction word; 32'd0 = bubble
- W_PC8  input  32  W-stage PC+8
- W_ALU_result  input  32  ALU result; bits [1:0] are the load byte offset
- W_MEM_read_data  input  32  raw aligned word from DM
- W_REG_write_number  input  5  destination register
- W_REG_write_enable  input  1  GRF write request
- W_WD_sel  input  2  0=ALU, 1=MEM (extended), 2=PC8, 3=reserved (treated as ALU)
- W_load_type  input  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; others treated as lw
- D_rs_number  input  5  read port A address
- D_rt_number  input  5  read port B address
- D_rs_data  output  32  read port A data
- D_rt_data  output  32  read port B data
- W_write_data  output  32  selected write-back value, for the forwarding network
- trace_valid  output  1  a GRF write committed last edge
- trace_pc  output  32  PC of that write (W_PC8-8)
- trace_number  output  5  register written
- trace_data  output  32  value written
- retire_count  output  CNT_W  non-bubble instructions retired

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - All 32 GRF entries = 0.
  - trace_valid=0, trace_pc=0, trace_number=0, trace_data=0, retire_count=0.
  - Release is sampled at the next rising edge.
  - Reset asserted mid-operation discards any pending write. No partial state survives.
- Load extension (combinational), off = W_ALU_result[1:0]:
  - lb/lbu select byte off: off=0 gives bits [7:0], off=3 gives bits [31:24]. lb sign-extends, lbu zero-extends.
  - lh/lhu select the halfword at off[1]. lh sign-extends, lhu zero-extends. off[0] is ignored (alignment is the M stage's responsibility).
- W_write_data (combinational): mux per W_WD_sel, using the extended MEM value when W_WD_sel=1.
- Commit condition: W_REG_write_enable=1 AND W_REG_write_number!=0.
- On each rising edge with commit:
  - GRF[num] <= W_write_data.
  - trace_valid<=1, trace_pc<=W_PC8-32'd8 (modulo 2^32), trace_number<=num, trace_data<=W_write_data.
- On each rising edge without commit: trace_valid<=0; other trace outputs hold.
- Register 0: never written; always reads 0 even if enable=1 with number 0. Number 0 produces no trace event.
- Read ports, zero-cycle latency:
  - D_rs_data = 0 if D_rs_number==0.
  - Else W_write_data if commit and D_rs_number==W_REG_write_number (write-through bypass).
  - Else GRF[D_rs_number].
  - D_rt_data follows the same rules. Both ports may hit the same register and the bypass simultaneously.
- retire_count: increments by 1 on every rising edge where W_instr!=32'd0, independent of write enable (stores and branches count). Wraps 2^CNT_W-1 -> 0 silently.
- No stall input: the W stage never stalls; holding is the M/W register's job.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> all outputs 0 immediately, before the next edge. Reading any register returns 0 after release.
- Write/read: write $5=32'hDEAD_BEEF (sel=0), PC8=32'h0000_300C. Same cycle D_rs_number=5 -> D_rs_data=DEADBEEF (bypass). Next cycle trace_valid=1, trace_pc=32'h0000_3004, trace_number=5. Later read of $5 without a write returns DEADBEEF from storage.
- $0 guard: enable=1, number=0, data=32'h1234 -> no trace event. D_rs_number=0 -> 0. retire_count still increments if W_instr!=0.
- Loads: MEM=32'h80FF_7F01.
  - lb off=2 -> FFFF_FFFF.
  - lbu off=3 -> 0000_0080.
  - lh off=2 -> FFFF_80FF.
  - lhu off=0 -> 0000_7F01.
  - lw -> 80FF_7F01.
- Jal path: sel=2, PC8=32'h0000_3010, number=31 -> $31=0000_3010, trace_pc=0000_3008.
- Counter: preset bench drives 5 non-bubble and 3 bubble (instr=0) cycles -> retire_count=5. A forced-wrap run with CNT_W=4 after 16 retirements -> 0.

Source files
------------

// File: rtl/w_stage_grf.sv
// Write-back end of the M/W pipeline: source select, sub-word load extension,
// 32x32 register file with write-through read ports, retire counter and write trace.
module w_stage_grf #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      W_instr,
  input  logic [31:0]      W_PC8,
  input  logic [31:0]      W_ALU_result,
  input  logic [31:0]      W_MEM_read_data,
  input  logic [4:0]       W_REG_write_number,
  input  logic             W_REG_write_enable,
  input  logic [1:0]       W_WD_sel,
  input  logic [2:0]       W_load_type,
  input  logic [4:0]       D_rs_number,
  input  logic [4:0]       D_rt_number,
  output logic [31:0]      D_rs_data,
  output logic [31:0]      D_rt_data,
  output logic [31:0]      W_write_data,
  output logic             trace_valid,
  output logic [31:0]      trace_pc,
  output logic [4:0]       trace_number,
  output logic [31:0]      trace_data,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC8 = 2'd2;

  // The base PC only matters to whoever interprets trace_pc.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ltype);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    byte_s = word[{off, 3'b000} +: 8];
    half_s = off[1] ? word[31:16] : word[15:0];
    case (ltype)
      LT_LB:   res = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  res = {24'd0, byte_s};
      LT_LH:   res = {{16{half_s[15]}}, half_s};
      LT_LHU:  res = {16'd0, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  logic [31:0]      grf_q [32];
  logic             trace_valid_q, trace_valid_d;
  logic [31:0]      trace_pc_q,    trace_pc_d;
  logic [4:0]       trace_number_q, trace_number_d;
  logic [31:0]      trace_data_q,  trace_data_d;
  logic [CNT_W-1:0] retire_q,      retire_d;
  logic             commit;

  always_comb begin
    W_write_data = W_ALU_result;
    case (W_WD_sel)
      SEL_MEM: W_write_data = extend_load(W_MEM_read_data, W_ALU_result[1:0], W_load_type);
      SEL_PC8: W_write_data = W_PC8;
      default: W_write_data = W_ALU_result;
    endcase
  end

  assign commit = W_REG_write_enable && (W_REG_write_number != 5'd0);

  // Same-cycle writes are visible to D-stage reads without waiting for the edge.
  always_comb begin
    D_rs_data = grf_q[D_rs_number];
    if (D_rs_number == 5'd0)
      D_rs_data = 32'd0;
    else if (commit && (D_rs_number == W_REG_write_number))
      D_rs_data = W_write_data;

    D_rt_data = grf_q[D_rt_number];
    if (D_rt_number == 5'd0)
      D_rt_data = 32'd0;
    else if (commit && (D_rt_number == W_REG_write_number))
      D_rt_data = W_write_data;
  end

  always_comb begin
    trace_valid_d  = commit;
    trace_pc_d     = trace_pc_q;
    trace_number_d = trace_number_q;
    trace_data_d   = trace_data_q;
    if (commit) begin
      trace_pc_d     = W_PC8 - 32'd8;
      trace_number_d = W_REG_write_number;
      trace_data_d   = W_write_data;
    end
    retire_d = (W_instr != 32'd0) ? retire_q + CNT_W'(1) : retire_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= 32'd0;
    end else if (commit) begin
      grf_q[W_REG_write_number] <= W_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid_q  <= 1'b0;
      trace_pc_q     <= 32'd0;
      trace_number_q <= 5'd0;
      trace_data_q   <= 32'd0;
      retire_q       <= '0;
    end else begin
      trace_valid_q  <= trace_valid_d;
      trace_pc_q     <= trace_pc_d;
      trace_number_q <= trace_number_d;
      trace_data_q   <= trace_data_d;
      retire_q       <= retire_d;
    end
  end

  assign trace_valid  = trace_valid_q;
  assign trace_pc     = trace_pc_q;
  assign trace_number = trace_number_q;
  assign trace_data   = trace_data_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_w_stage_grf.sv
// Directed bench for w_stage_grf: a 32-bit counter instance plus a 4-bit
// counter instance sharing the same stimulus for the wrap case.
module tb_w_stage_grf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] W_instr, W_PC8, W_ALU_result, W_MEM_read_data;
  logic [4:0]  W_REG_write_number;
  logic        W_REG_write_enable;
  logic [1:0]  W_WD_sel;
  logic [2:0]  W_load_type;
  logic [4:0]  D_rs_number, D_rt_number;

  logic [31:0] D_rs_data, D_rt_data, W_write_data, trace_pc, trace_data, retire_count;
  logic        trace_valid;
  logic [4:0]  trace_number;

  logic [31:0] s_rs, s_rt, s_wd, s_tpc, s_tdata;
  logic        s_tvalid;
  logic [4:0]  s_tnum;
  logic [3:0]  s_retire;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  w_stage_grf #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .W_instr(W_instr), .W_PC8(W_PC8),
    .W_ALU_result(W_ALU_result), .W_MEM_read_data(W_MEM_read_data),
    .W_REG_write_number(W_REG_write_number), .W_REG_write_enable(W_REG_write_enable),
    .W_WD_sel(W_WD_sel), .W_load_type(W_load_type),
    .D_rs_number(D_rs_number), .D_rt_number(D_rt_number),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .W_write_data(W_write_data),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_number(trace_number),
    .trace_data(trace_data), .retire_count(retire_count)
  );

  w_stage_grf #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .W_instr(W_instr), .W_PC8(W_PC8),
    .W_ALU_result(W_ALU_result), .W_MEM_read_data(W_MEM_read_data),
    .W_REG_write_number(W_REG_write_number), .W_REG_write_enable(W_REG_write_enable),
    .W_WD_sel(W_WD_sel), .W_load_type(W_load_type),
    .D_rs_number(D_rs_number), .D_rt_number(D_rt_number),
    .D_rs_data(s_rs), .D_rt_data(s_rt), .W_write_data(s_wd),
    .trace_valid(s_tvalid), .trace_pc(s_tpc), .trace_number(s_tnum),
    .trace_data(s_tdata), .retire_count(s_retire)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc8,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] num, input logic we,
                       input logic [1:0] sel, input logic [2:0] lt);
    W_instr = instr; W_PC8 = pc8; W_ALU_result = alu; W_MEM_read_data = mem;
    W_REG_write_number = num; W_REG_write_enable = we; W_WD_sel = sel; W_load_type = lt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    D_rs_number = 5'd0; D_rt_number = 5'd0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    D_rs_number = 5'd5;
    #1;
    chk("rst_tvalid", 32'(trace_valid), 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_rs5", D_rs_data, 32'd0);

    // Commit something, then reset mid-cycle: everything must clear immediately.
    drive(32'd1, 32'h0000_3020, 32'h55, 32'd0, 5'd7, 1'b1, 2'd0, 3'd0);
    tick();
    chk("pre_tvalid", 32'(trace_valid), 32'd1);
    chk("pre_retire", retire_count, 32'd1);
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0);
    D_rs_number = 5'd7; D_rt_number = 5'd7;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_tvalid", 32'(trace_valid), 32'd0);
    chk("mid_tpc", trace_pc, 32'd0);
    chk("mid_tnum", 32'(trace_number), 32'd0);
    chk("mid_tdata", trace_data, 32'd0);
    chk("mid_retire", retire_count, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_rs7", D_rs_data, 32'd0);
    chk("post_rt7", D_rt_data, 32'd0);

    // Write $5 with bypass on the same cycle.
    drive(32'h20, 32'h0000_300C, 32'hDEAD_BEEF, 32'd0, 5'd5, 1'b1, 2'd0, 3'd0);
    D_rs_number = 5'd5; D_rt_number = 5'd0;
    #1;
    chk("byp_rs5", D_rs_data, 32'hDEAD_BEEF);
    chk("byp_rt0", D_rt_data, 32'd0);
    chk("wd_alu", W_write_data, 32'hDEAD_BEEF);
    tick();
    chk("w5_tvalid", 32'(trace_valid), 32'd1);
    chk("w5_tpc", trace_pc, 32'h0000_3004);
    chk("w5_tnum", 32'(trace_number), 32'd5);
    chk("w5_tdata", trace_data, 32'hDEAD_BEEF);
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0);
    D_rt_number = 5'd5;
    #1;
    chk("store_rs5", D_rs_data, 32'hDEAD_BEEF);
    chk("store_rt5", D_rt_data, 32'hDEAD_BEEF);
    tick();
    chk("bub_tvalid", 32'(trace_valid), 32'd0);
    chk("bub_tnum_hold", 32'(trace_number), 32'd5);
    chk("bub_retire", retire_count, 32'd1);

    // $0 guard.
    drive(32'd1, 32'h0000_3040, 32'h1234, 32'd0, 5'd0, 1'b1, 2'd0, 3'd0);
    D_rs_number = 5'd0;
    #1;
    chk("r0_rs", D_rs_data, 32'd0);
    tick();
    chk("r0_tvalid", 32'(trace_valid), 32'd0);
    chk("r0_tdata_hold", trace_data, 32'hDEAD_BEEF);
    chk("r0_retire", retire_count, 32'd2);

    // Load extension, MEM = 80FF_7F01, destination $8.
    D_rs_number = 5'd8;
    drive(32'd1, 32'h0000_3050, 32'd2, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd1); #1;
    chk("lb_off2", W_write_data, 32'hFFFF_FFFF);
    tick();
    drive(32'd1, 32'h0000_3054, 32'd3, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd2); #1;
    chk("lbu_off3", W_write_data, 32'h0000_0080);
    tick();
    drive(32'd1, 32'h0000_3058, 32'd2, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd3); #1;
    chk("lh_off2", W_write_data, 32'hFFFF_80FF);
    tick();
    drive(32'd1, 32'h0000_305C, 32'd0, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd4); #1;
    chk("lhu_off0", W_write_data, 32'h0000_7F01);
    tick();
    drive(32'd1, 32'h0000_3060, 32'd0, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd0); #1;
    chk("lw", W_write_data, 32'h80FF_7F01);
    tick();
    drive(32'd1, 32'h0000_3064, 32'd0, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd2); #1;
    chk("lbu_off0", W_write_data, 32'h0000_0001);
    tick();
    drive(32'd1, 32'h0000_3068, 32'd3, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd4); #1;
    chk("lhu_off3", W_write_data, 32'h0000_80FF);
    tick();
    drive(32'd1, 32'h0000_306C, 32'd1, 32'h80FF_7F01, 5'd8, 1'b1, 2'd1, 3'd6); #1;
    chk("ltype6_lw", W_write_data, 32'h80FF_7F01);
    chk("load_byp_rs8", D_rs_data, 32'h80FF_7F01);
    tick();
    chk("load_retire", retire_count, 32'd10);

    // jal link and reserved select.
    drive(32'd1, 32'h0000_3010, 32'h0000_AAAA, 32'd0, 5'd31, 1'b1, 2'd2, 3'd0); #1;
    chk("jal_wd", W_write_data, 32'h0000_3010);
    tick();
    chk("jal_tpc", trace_pc, 32'h0000_3008);
    chk("jal_tnum", 32'(trace_number), 32'd31);
    chk("jal_tdata", trace_data, 32'h0000_3010);
    drive(32'd1, 32'h0000_3014, 32'h0BAD_F00D, 32'h1111_1111, 5'd9, 1'b1, 2'd3, 3'd0); #1;
    chk("sel3_wd", W_write_data, 32'h0BAD_F00D);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0);
    D_rs_number = 5'd31; D_rt_number = 5'd9;
    #1;
    chk("rd_r31", D_rs_data, 32'h0000_3010);
    chk("rd_r9", D_rt_data, 32'h0BAD_F00D);
    chk("sel3_tpc", trace_pc, 32'h0000_300C);

    // Both ports bypassing the same register; trace_pc wraps below zero.
    drive(32'd1, 32'd4, 32'h1111_2222, 32'd0, 5'd9, 1'b1, 2'd0, 3'd0);
    D_rs_number = 5'd9; D_rt_number = 5'd9;
    #1;
    chk("dual_rs", D_rs_data, 32'h1111_2222);
    chk("dual_rt", D_rt_data, 32'h1111_2222);
    tick();
    chk("wrap_tpc", trace_pc, 32'hFFFF_FFFC);
    chk("dual_retire", retire_count, 32'd13);

    // Counter: 5 retirements, 3 bubbles, then wrap of the 4-bit instance.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive((i % 3 == 1) ? 32'd0 : 32'h0000_0013 + i, 32'd8, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0);
      tick();
    end
    chk("cnt_5", retire_count, 32'd5);
    chk("cnt4_5", 32'(s_retire), 32'd5);
    for (int i = 0; i < 10; i++) begin
      drive(32'hFFFF_FFFF, 32'd8, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0);
      tick();
    end
    chk("cnt4_15", 32'(s_retire), 32'd15);
    tick();
    chk("cnt4_wrap", 32'(s_retire), 32'd0);
    chk("cnt_16", retire_count, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
